// File: rtl/lcd_ctrl.sv
// HD44780 4-bit LCD controller: power-up init, then byte writes over valid/ready.
// Define LCD_FAST_SIM_EN to divide the long waits by 1000 for simulation.
module lcd_ctrl #(
    parameter int unsigned T_PWRUP = 720000,
    parameter int unsigned T_INIT1 = 196800,
    parameter int unsigned T_INIT2 = 4800,
    parameter int unsigned T_AS    = 3,
    parameter int unsigned T_EW    = 12,
    parameter int unsigned T_NIB   = 48,
    parameter int unsigned T_CMD   = 1920,
    parameter int unsigned T_CLR   = 78720
) (
    input  logic       clk_48Mhz,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    function automatic int unsigned scale(input int unsigned n);
`ifdef LCD_FAST_SIM_EN
        return (n / 1000 == 0) ? 1 : n / 1000;
`else
        return n;
`endif
    endfunction

    function automatic logic [19:0] load(input int unsigned n);
        return (n == 0) ? 20'd0 : 20'(n - 1);
    endfunction

    localparam logic [19:0] L_PWRUP = load(scale(T_PWRUP));
    localparam logic [19:0] L_INIT1 = load(scale(T_INIT1));
    localparam logic [19:0] L_INIT2 = load(scale(T_INIT2));
    localparam logic [19:0] L_CMD   = load(scale(T_CMD));
    localparam logic [19:0] L_CLR   = load(scale(T_CLR));
    localparam logic [19:0] L_AS    = load(T_AS);
    localparam logic [19:0] L_EW    = load(T_EW);
    localparam logic [19:0] L_NIB   = load(T_NIB);

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_NIB, SETUP_HI, PULSE_HI, GAP,
        SETUP_LO, PULSE_LO, EXEC_WAIT, IDLE
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h28;
            3'd1:    return 8'h08;
            3'd2:    return 8'h01;
            3'd3:    return 8'h06;
            default: return 8'h0C;
        endcase
    endfunction

    function automatic logic [19:0] nib_wait(input logic [1:0] idx);
        case (idx)
            2'd0:    return L_INIT1;
            2'd1:    return L_INIT2;
            default: return L_CMD;
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    function automatic logic is_slow(input logic rs, input logic [7:0] d);
        return !rs && (d[7:2] == 6'd0) && (d != 8'h00);
    endfunction

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  nib_idx_q, nib_idx_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic        init_q, init_d;
    logic        armed_q, armed_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        in_ready_q, in_ready_d;
    logic        init_done_q, init_done_d;
    logic        lcd_e_q, lcd_e_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic [3:0]  lcd_db_q, lcd_db_d;
    logic        cnt_done;

    assign cnt_done = (cnt_q == 20'd0);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        nib_idx_d  = nib_idx_q;
        byte_idx_d = byte_idx_q;
        init_d     = init_q;
        armed_d    = armed_q;
        data_d     = data_q;
        rs_d       = rs_q;

        case (state_q)
            PWR_WAIT: begin
                if (!armed_q) begin
                    armed_d = 1'b1;
                    cnt_d   = L_PWRUP;
                end else if (!cnt_done) begin
                    cnt_d = cnt_q - 20'd1;
                end else begin
                    state_d   = INIT_NIB;
                    phase_d   = PH_SETUP;
                    nib_idx_d = 2'd0;
                    cnt_d     = L_AS;
                end
            end
            INIT_NIB: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 20'd1;
                end else begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_d = PH_PULSE;
                            cnt_d   = L_EW;
                        end
                        PH_PULSE: begin
                            phase_d = PH_WAIT;
                            cnt_d   = nib_wait(nib_idx_q);
                        end
                        default: begin
                            cnt_d = L_AS;
                            if (nib_idx_q == 2'd3) begin
                                state_d    = SETUP_HI;
                                init_d     = 1'b1;
                                byte_idx_d = 3'd0;
                                data_d     = init_rom(3'd0);
                                rs_d       = 1'b0;
                            end else begin
                                nib_idx_d = nib_idx_q + 2'd1;
                                phase_d   = PH_SETUP;
                            end
                        end
                    endcase
                end
            end
            SETUP_HI: begin
                if (!cnt_done) cnt_d = cnt_q - 20'd1;
                else begin state_d = PULSE_HI; cnt_d = L_EW; end
            end
            PULSE_HI: begin
                if (!cnt_done) cnt_d = cnt_q - 20'd1;
                else begin state_d = GAP; cnt_d = L_NIB; end
            end
            GAP: begin
                if (!cnt_done) cnt_d = cnt_q - 20'd1;
                else begin state_d = SETUP_LO; cnt_d = L_AS; end
            end
            SETUP_LO: begin
                if (!cnt_done) cnt_d = cnt_q - 20'd1;
                else begin state_d = PULSE_LO; cnt_d = L_EW; end
            end
            PULSE_LO: begin
                if (!cnt_done) cnt_d = cnt_q - 20'd1;
                else begin
                    state_d = EXEC_WAIT;
                    cnt_d   = is_slow(rs_q, data_q) ? L_CLR : L_CMD;
                end
            end
            EXEC_WAIT: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 20'd1;
                end else if (init_q && byte_idx_q != 3'd4) begin
                    byte_idx_d = byte_idx_q + 3'd1;
                    data_d     = init_rom(byte_idx_q + 3'd1);
                    state_d    = SETUP_HI;
                    cnt_d      = L_AS;
                end else begin
                    init_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rs_d    = in_rs;
                    state_d = SETUP_HI;
                    cnt_d   = L_AS;
                end
            end
            default: begin
                state_d = PWR_WAIT;
                armed_d = 1'b0;
            end
        endcase

        // Pin values follow the next state so every output is a clean flop.
        in_ready_d  = (state_d == IDLE);
        init_done_d = init_done_q | (state_d == IDLE);
        lcd_e_d     = (state_d == PULSE_HI) || (state_d == PULSE_LO) ||
                      ((state_d == INIT_NIB) && (phase_d == PH_PULSE));
        lcd_rs_d    = lcd_rs_q;
        lcd_db_d    = lcd_db_q;
        case (state_d)
            INIT_NIB: begin
                lcd_rs_d = 1'b0;
                lcd_db_d = (nib_idx_d == 2'd3) ? 4'h2 : 4'h3;
            end
            SETUP_HI, PULSE_HI, GAP: begin
                lcd_rs_d = rs_d;
                lcd_db_d = data_d[7:4];
            end
            SETUP_LO, PULSE_LO: begin
                lcd_rs_d = rs_d;
                lcd_db_d = data_d[3:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_48Mhz) begin
        if (!rst) begin
            state_q     <= PWR_WAIT;
            phase_q     <= PH_SETUP;
            cnt_q       <= 20'd0;
            nib_idx_q   <= 2'd0;
            byte_idx_q  <= 3'd0;
            init_q      <= 1'b0;
            armed_q     <= 1'b0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_db_q    <= 4'h0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            nib_idx_q   <= nib_idx_d;
            byte_idx_q  <= byte_idx_d;
            init_q      <= init_d;
            armed_q     <= armed_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            in_ready_q  <= in_ready_d;
            init_done_q <= init_done_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_db_q    <= lcd_db_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign init_done = init_done_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_db    = lcd_db_q;

endmodule
